// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits, LSB first, optional odd parity, one stop bit.
// Accepts a byte through a valid/ready handshake and reports frame completion with a one-cycle pulse.
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift, shift_n;
  logic             parity, parity_n;
  logic             tx_n;
  logic             done_n;
  logic             bit_end;

  assign o_ready = (state == IDLE);
  assign o_busy  = (state != IDLE);
  assign bit_end = (baud_cnt == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      parity   <= 1'b0;
      o_tx     <= 1'b1;
      o_done   <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shift    <= shift_n;
      parity   <= parity_n;
      o_tx     <= tx_n;
      o_done   <= done_n;
    end
  end

  // The line level is computed one cycle ahead so o_tx comes straight from a flop.
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    shift_n    = shift;
    parity_n   = parity;
    tx_n       = o_tx;
    done_n     = 1'b0;

    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (i_valid) begin
          shift_n    = i_data;
          parity_n   = ~^i_data;
          baud_cnt_n = '0;
          state_n    = START;
          tx_n       = 1'b0;
        end
      end

      START: begin
        if (bit_end) begin
          baud_cnt_n = '0;
          bit_idx_n  = '0;
          state_n    = DATA;
          tx_n       = shift[0];
        end else begin
          baud_cnt_n = baud_cnt + ONE;
        end
      end

      DATA: begin
        if (bit_end) begin
          baud_cnt_n = '0;
          if (bit_idx == 3'd7) begin
            if (PARITY_EN != 0) begin
              state_n = PARITY;
              tx_n    = parity;
            end else begin
              state_n = STOP;
              tx_n    = 1'b1;
            end
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            shift_n   = {1'b0, shift[7:1]};
            tx_n      = shift[1];
          end
        end else begin
          baud_cnt_n = baud_cnt + ONE;
        end
      end

      PARITY: begin
        if (bit_end) begin
          baud_cnt_n = '0;
          state_n    = STOP;
          tx_n       = 1'b1;
        end else begin
          baud_cnt_n = baud_cnt + ONE;
        end
      end

      STOP: begin
        tx_n = 1'b1;
        if (bit_end) begin
          baud_cnt_n = '0;
          state_n    = IDLE;
          done_n     = 1'b1;
        end else begin
          baud_cnt_n = baud_cnt + ONE;
        end
      end

      default: begin
        state_n    = IDLE;
        baud_cnt_n = '0;
        tx_n       = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: one instance with parity, one without, sharing clock and reset.
// Expected frames are queued on acceptance and compared cycle by cycle as the line toggles.
module tb_uart_tx;

  localparam int BIT_CYC = 4;

  logic       clk;
  logic       rst_n;
  logic       vld [2];
  logic [7:0] dat [2];
  logic       rdy_s [2];
  logic       tx_s [2];
  logic       busy_s [2];
  logic       done_s [2];

  logic       ready_p, tx_p, busy_p, done_p;
  logic       ready_n, tx_n, busy_n, done_n;

  int total = 0;
  int bad   = 0;

  logic [7:0]  exp_q0 [$];
  logic [7:0]  exp_q1 [$];
  logic [10:0] bits [2];
  int          pos [2];
  int          cyc [2];
  int          nb [2];
  bit          active [2];
  bit          exp_done [2];
  bit          b2b_pending [2];
  int          done_count [2];

  uart_tx #(.CLKS_PER_BIT(BIT_CYC), .PARITY_EN(1)) dut_p (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(dat[0]), .i_valid(vld[0]),
    .o_ready(ready_p), .o_tx(tx_p), .o_busy(busy_p), .o_done(done_p)
  );

  uart_tx #(.CLKS_PER_BIT(BIT_CYC), .PARITY_EN(0)) dut_n (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(dat[1]), .i_valid(vld[1]),
    .o_ready(ready_n), .o_tx(tx_n), .o_busy(busy_n), .o_done(done_n)
  );

  assign rdy_s[0]  = ready_p;
  assign rdy_s[1]  = ready_n;
  assign tx_s[0]   = tx_p;
  assign tx_s[1]   = tx_n;
  assign busy_s[0] = busy_p;
  assign busy_s[1] = busy_n;
  assign done_s[0] = done_p;
  assign done_s[1] = done_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Line image of a frame, bit 0 first: start, data LSB first, parity (odd), stop.
  function automatic logic [10:0] frameBits(input logic [7:0] b, input bit par_en);
    int ones;
    logic [10:0] f;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
    if (par_en) f[9] = ((ones % 2) == 0);
    return f;
  endfunction

  function automatic int qSize(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  // Presents a byte and holds i_valid until a ready cycle, then queues the expected frame.
  task automatic applyStimulus(input int d, input logic [7:0] b);
    bit ok;
    ok     = 1'b0;
    vld[d] = 1'b1;
    dat[d] = b;
    for (int k = 0; k < 200; k++) begin
      if (rdy_s[d]) begin
        ok = 1'b1;
        if (d == 0) exp_q0.push_back(b);
        else        exp_q1.push_back(b);
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    if (!ok) checkOutput($sformatf("accept_timeout_d%0d", d), 8'd0, 8'd1);
  endtask

  task automatic waitIdle(input int d);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (qSize(d) == 0 && !active[d] && !exp_done[d] && !busy_s[d]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput($sformatf("idle_timeout_d%0d", d), 8'd0, 8'd1);
  endtask

  // Scoreboard monitor: pops a frame when busy rises and checks every cycle of it.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        active[d]      = 1'b0;
        exp_done[d]    = 1'b0;
        b2b_pending[d] = 1'b0;
      end else if (exp_done[d]) begin
        checkOutput($sformatf("d%0d_done_pulse", d), 8'(done_s[d]), 8'd1);
        checkOutput($sformatf("d%0d_done_ready", d), 8'(rdy_s[d]), 8'd1);
        checkOutput($sformatf("d%0d_done_busy", d), 8'(busy_s[d]), 8'd0);
        checkOutput($sformatf("d%0d_done_tx", d), 8'(tx_s[d]), 8'd1);
        exp_done[d]    = 1'b0;
        b2b_pending[d] = vld[d];
        done_count[d]++;
      end else begin
        if (b2b_pending[d]) begin
          checkOutput($sformatf("d%0d_b2b_start", d), 8'(busy_s[d]), 8'd1);
          b2b_pending[d] = 1'b0;
        end
        if (!active[d] && busy_s[d]) begin
          logic [7:0] b;
          b = 8'h00;
          if (qSize(d) == 0) checkOutput($sformatf("d%0d_unexpected_frame", d), 8'd1, 8'd0);
          else if (d == 0) b = exp_q0.pop_front();
          else             b = exp_q1.pop_front();
          bits[d]   = frameBits(b, d == 0);
          nb[d]     = (d == 0) ? 11 : 10;
          pos[d]    = 0;
          cyc[d]    = 0;
          active[d] = 1'b1;
        end
        if (active[d]) begin
          checkOutput($sformatf("d%0d_tx_bit%0d", d, pos[d]), 8'(tx_s[d]), 8'(bits[d][pos[d]]));
          checkOutput($sformatf("d%0d_busy_bit%0d", d, pos[d]), 8'(busy_s[d]), 8'd1);
          checkOutput($sformatf("d%0d_early_done", d), 8'(done_s[d]), 8'd0);
          cyc[d]++;
          if (cyc[d] == BIT_CYC) begin
            cyc[d] = 0;
            pos[d]++;
            if (pos[d] == nb[d]) begin
              active[d]   = 1'b0;
              exp_done[d] = 1'b1;
            end
          end
        end else begin
          checkOutput($sformatf("d%0d_idle_tx", d), 8'(tx_s[d]), 8'd1);
          checkOutput($sformatf("d%0d_idle_done", d), 8'(done_s[d]), 8'd0);
          checkOutput($sformatf("d%0d_idle_ready", d), 8'(rdy_s[d]), 8'd1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n  = 1'b0;
    vld[0] = 1'b0;
    vld[1] = 1'b0;
    dat[0] = 8'h00;
    dat[1] = 8'h00;
    for (int d = 0; d < 2; d++) begin
      active[d]      = 1'b0;
      exp_done[d]    = 1'b0;
      b2b_pending[d] = 1'b0;
      done_count[d]  = 0;
    end

    #12;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("d%0d_reset_tx", d), 8'(tx_s[d]), 8'd1);
      checkOutput($sformatf("d%0d_reset_busy", d), 8'(busy_s[d]), 8'd0);
      checkOutput($sformatf("d%0d_reset_ready", d), 8'(rdy_s[d]), 8'd1);
      checkOutput($sformatf("d%0d_reset_done", d), 8'(done_s[d]), 8'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(0, 8'h55);
    vld[0] = 1'b0;
    waitIdle(0);
    applyStimulus(0, 8'h07);
    vld[0] = 1'b0;
    waitIdle(0);
    applyStimulus(0, 8'h00);
    vld[0] = 1'b0;
    waitIdle(0);

    applyStimulus(1, 8'hA3);
    vld[1] = 1'b0;
    waitIdle(1);

    // Valid held across both frames: the second byte must wait for the done cycle.
    applyStimulus(0, 8'hFF);
    applyStimulus(0, 8'h12);
    vld[0] = 1'b0;
    waitIdle(0);

    // Abandon a frame partway through the data bits.
    applyStimulus(0, 8'hC3);
    vld[0] = 1'b0;
    repeat (14) @(negedge clk);
    #1;
    checkOutput("pre_reset_busy", 8'(busy_s[0]), 8'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_tx", 8'(tx_s[0]), 8'd1);
    checkOutput("async_reset_busy", 8'(busy_s[0]), 8'd0);
    checkOutput("async_reset_ready", 8'(rdy_s[0]), 8'd1);
    checkOutput("async_reset_done", 8'(done_s[0]), 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 8'h55);
    vld[0] = 1'b0;
    checkOutput("accept_after_reset", 8'(busy_s[0]), 8'd1);
    waitIdle(0);

    repeat (3) @(negedge clk);
    checkOutput("d0_done_count", 8'(done_count[0]), 8'd6);
    checkOutput("d1_done_count", 8'(done_count[1]), 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
- REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, giving the number of i_clk cycles per serial bit; legal values are 2 or more.
- REQ-002 SHALL have parameter PARITY_EN, default 1; 1 inserts a parity bit, 0 omits it.
- REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-004 SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
- REQ-005 SHALL have port i_data, input, 8 bits: byte to transmit, sampled at acceptance.
- REQ-006 SHALL have port i_valid, input, 1 bit: i_data is valid this cycle.
- REQ-007 SHALL have port o_ready, output, 1 bit: the block can accept a byte this cycle.
- REQ-008 SHALL have port o_tx, output, 1 bit: serial line; idle level is 1.
- REQ-009 SHALL have port o_busy, output, 1 bit: a frame is in progress.
- REQ-010 SHALL have port o_done, output, 1 bit: one-cycle pulse at frame completion.

Function
- REQ-011 SHALL implement states IDLE, START, DATA, PARITY and STOP.
- REQ-012 SHALL accept a byte when i_valid=1 and o_ready=1 on a rising edge, latch i_data into a shift register and compute the parity bit at that edge.
- REQ-013 SHALL assert o_ready only in IDLE and SHALL ignore i_valid in all other states; the latched byte is unaffected.
- REQ-014 SHALL generate the parity bit as 1 when the latched byte has an even number of 1s, else 0 (odd parity over data plus parity bit); the same rule as the team's parity checker.
- REQ-015 SHALL enter START on the cycle after acceptance and drive o_tx=0 for exactly CLKS_PER_BIT cycles.
- REQ-016 SHALL in DATA send bits 0 through 7, LSB first, each held for exactly CLKS_PER_BIT cycles, using a 3-bit bit index.
- REQ-017 SHALL go from DATA to PARITY if PARITY_EN=1 (parity bit held CLKS_PER_BIT cycles), else directly to STOP.
- REQ-018 SHALL in STOP drive o_tx=1 for CLKS_PER_BIT cycles, then return to IDLE.
- REQ-019 SHALL use a baud counter of $clog2(CLKS_PER_BIT) bits counting 0 to CLKS_PER_BIT-1.
- REQ-020 SHALL clear the baud counter on every state change; the bit ends when the count reaches CLKS_PER_BIT-1.
- REQ-021 SHALL make the total frame time 11*CLKS_PER_BIT cycles with parity and 10*CLKS_PER_BIT without.
- REQ-022 SHALL pulse o_done=1 for exactly one cycle, the first IDLE cycle after STOP.
- REQ-023 SHALL have o_ready=1 in that same o_done cycle.
- REQ-024 SHALL accept a byte presented in the o_done cycle, so the next START begins on the following cycle; back-to-back frames have no idle bit between them.
- REQ-025 SHALL hold o_busy=1 in START, DATA, PARITY and STOP, and 0 in IDLE.
- REQ-026 SHALL drive o_tx from a register (glitch-free), with o_tx=1 in IDLE.

Reset
- REQ-027 SHALL on i_rst_n=0, immediately and independently of i_clk, force state to IDLE.
- REQ-028 SHALL on i_rst_n=0 also force o_tx=1, o_ready=1, o_busy=0, o_done=0, and clear the baud counter, bit index and shift register to 0.
- REQ-029 SHALL abandon a frame interrupted by reset with no o_done pulse.
- REQ-030 SHALL accept a new byte on the first rising edge after i_rst_n returns to 1.

Verification (CLKS_PER_BIT=4)
- REQ-031 SHALL cover: PARITY_EN=1, send 0x55 -> o_tx sequence 0,1,0,1,0,1,0,1,0,1(parity),1(stop), each bit 4 cycles; 44 cycles; one o_done pulse.
- REQ-032 SHALL cover: send 0x07 -> data bits 1,1,1,0,0,0,0,0, parity 0; send 0x00 -> parity 1.
- REQ-033 SHALL cover: PARITY_EN=0, send 0xA3 -> bits 0,1,1,0,0,0,1,0,1,1 (stop); 40 cycles.
- REQ-034 SHALL cover: i_valid held with 0xFF then 0x12 back-to-back -> second START immediately follows the first STOP with no idle gap; i_valid ignored while busy.
- REQ-035 SHALL cover: i_rst_n=0 asserted mid-DATA -> o_tx=1, o_busy=0, o_ready=1 without waiting for a clock edge; no o_done.
- REQ-036 SHALL cover: after REQ-035, a fresh 0x55 -> correct full frame as in REQ-031.
